// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX/MEM, MEM/WB operand forwarding.
// The ALU operands and store data are combinational on the registered stage plus the forwarding inputs.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [3:0]        id_alu_ctrl,
    input  logic [4:0]        id_shamt,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              exm_reg_write,
    input  logic [REG_W-1:0]  exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_W-1:0]  mwb_rd,
    input  logic [DATA_W-1:0] mwb_result,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        alu_ctrl,
    output logic [4:0]        alu_shamt,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              load_use_stall
);

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [DATA_W-1:0] imm;
        logic [3:0]        alu_ctrl;
        logic [4:0]        shamt;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } ex_reg_t;

    ex_reg_t ex_q;
    ex_reg_t id_d;
    logic [DATA_W-1:0] fwd_rs, fwd_rt;

    assign id_d = '{valid: id_valid, rs: id_rs, rt: id_rt, rd: id_rd,
                    rs_val: id_rs_val, rt_val: id_rt_val, imm: id_imm,
                    alu_ctrl: id_alu_ctrl, shamt: id_shamt, alu_src: id_alu_src,
                    reg_write: id_reg_write, mem_read: id_mem_read,
                    mem_write: id_mem_write};

    // A squashed ID slot can never cause a hazard, so flush masks the stall request.
    assign load_use_stall = !flush && id_valid && ex_q.valid && ex_q.mem_read &&
                            (ex_q.rd != '0) && ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));

    always_ff @(posedge clk) begin
        if (rst)
            ex_q <= '0;
        else if (stall_in)
            ex_q <= ex_q;
        else if (flush || load_use_stall)
            ex_q <= '0;
        else
            ex_q <= id_d;
    end

    // EX/MEM is the younger producer, so it takes precedence; r0 is hardwired and never forwarded.
    function automatic logic [DATA_W-1:0] fwd(input logic [REG_W-1:0] r,
                                              input logic [DATA_W-1:0] v);
        if (r == '0)
            return v;
        else if (exm_reg_write && exm_rd == r)
            return exm_result;
        else if (mwb_reg_write && mwb_rd == r)
            return mwb_result;
        else
            return v;
    endfunction

    assign fwd_rs = fwd(ex_q.rs, ex_q.rs_val);
    assign fwd_rt = fwd(ex_q.rt, ex_q.rt_val);

    assign alu_in1       = fwd_rs;
    assign alu_in2       = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_ctrl      = ex_q.alu_ctrl;
    assign alu_shamt     = ex_q.shamt;
    assign ex_rd         = ex_q.rd;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
    assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
    assign ex_mem_write  = ex_q.valid & ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected stage outputs are queued as stimulus is driven
// and popped/compared once the edge (or forwarding change) has produced them.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_val, id_rt_val, id_imm;
    logic [3:0]  id_alu_ctrl;
    logic [4:0]  id_shamt;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic        stall_in, flush;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_result;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0]  alu_ctrl;
    logic [4:0]  alu_shamt, ex_rd;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

    int ncmp = 0;
    int nerr = 0;

    typedef struct {
        logic        ev, erw, emr, emw;
        logic [4:0]  rd;
        logic [31:0] in1, in2, sd;
        logic [3:0]  ctrl;
        logic [4:0]  shamt;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_alu_ctrl(id_alu_ctrl), .id_shamt(id_shamt), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .stall_in(stall_in), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_shamt(alu_shamt),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
        .load_use_stall(load_use_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic ev, erw, emr, emw, input logic [4:0] rd,
                        input logic [31:0] in1, in2, sd, input logic [3:0] ctrl,
                        input logic [4:0] shamt);
        exp_t e;
        e.ev = ev; e.erw = erw; e.emr = emr; e.emw = emw; e.rd = rd;
        e.in1 = in1; e.in2 = in2; e.sd = sd; e.ctrl = ctrl; e.shamt = shamt;
        sb.push_back(e);
    endtask

    task automatic sample(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".ex_valid"},     {31'd0, ex_valid},     {31'd0, e.ev});
            check({tag, ".ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, e.erw});
            check({tag, ".ex_mem_read"},  {31'd0, ex_mem_read},  {31'd0, e.emr});
            check({tag, ".ex_mem_write"}, {31'd0, ex_mem_write}, {31'd0, e.emw});
            check({tag, ".ex_rd"},        {27'd0, ex_rd},        {27'd0, e.rd});
            check({tag, ".alu_in1"},      alu_in1,               e.in1);
            check({tag, ".alu_in2"},      alu_in2,               e.in2);
            check({tag, ".store_data"},   ex_store_data,         e.sd);
            check({tag, ".alu_ctrl"},     {28'd0, alu_ctrl},     {28'd0, e.ctrl});
            check({tag, ".alu_shamt"},    {27'd0, alu_shamt},    {27'd0, e.shamt});
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        sample(tag);
    endtask

    task automatic settle(input string tag);
        #1;
        sample(tag);
    endtask

    task automatic chk_lus(input string tag, input logic exp);
        #1;
        check(tag, {31'd0, load_use_stall}, {31'd0, exp});
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs, rt, rd,
                          input logic [31:0] rsv, rtv, imm, input logic [3:0] ctrl,
                          input logic [4:0] sh, input logic src, rw, mr, mw);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_val = rsv; id_rt_val = rtv; id_imm = imm;
        id_alu_ctrl = ctrl; id_shamt = sh;
        id_alu_src = src; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic fwd_set(input logic ew, input logic [4:0] er, input logic [31:0] ex,
                           input logic mw, input logic [4:0] mr, input logic [31:0] mx);
        exm_reg_write = ew; exm_rd = er; exm_result = ex;
        mwb_reg_write = mw; mwb_rd = mr; mwb_result = mx;
    endtask

    initial begin
        rst = 1'b1; stall_in = 1'b0; flush = 1'b0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fwd_set(0, 0, 0, 0, 0, 0);

        // Reset state
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("reset");
        rst = 1'b0;
        chk_lus("reset.lus", 1'b0);

        // Load r5 enters EX
        id_set(1, 1, 2, 5, 32'h100, 32'h200, 32'h8, 4'd0, 5'd0, 1, 1, 1, 0);
        chk_lus("load.lus", 1'b0);
        push(1, 1, 1, 0, 5, 32'h100, 32'h8, 32'h200, 4'd0, 5'd0);
        tick("load");

        // Dependent add: hazard raised now, bubble next cycle
        id_set(1, 5, 6, 7, 32'h11, 32'h22, 32'h0, 4'd0, 5'd0, 0, 1, 0, 0);
        chk_lus("hazard.lus", 1'b1);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("bubble");
        chk_lus("bubble.lus", 1'b0);
        push(1, 1, 0, 0, 7, 32'h11, 32'h22, 32'h22, 4'd0, 5'd0);
        tick("add");

        // EX/MEM beats MEM/WB, then MEM/WB alone, then registered value
        id_set(1, 3, 4, 8, 32'h1, 32'h2, 32'h0, 4'd2, 5'd3, 0, 1, 0, 0);
        fwd_set(1, 3, 32'hAA, 1, 3, 32'hBB);
        push(1, 1, 0, 0, 8, 32'hAA, 32'h2, 32'h2, 4'd2, 5'd3);
        tick("fwd_exm");
        stall_in = 1'b1;
        exm_reg_write = 1'b0;
        push(1, 1, 0, 0, 8, 32'hBB, 32'h2, 32'h2, 4'd2, 5'd3);
        settle("fwd_mwb");
        fwd_set(0, 0, 0, 1, 4, 32'hCC);
        push(1, 1, 0, 0, 8, 32'h1, 32'hCC, 32'hCC, 4'd2, 5'd3);
        settle("fwd_rt_mwb");
        push(1, 1, 0, 0, 8, 32'h1, 32'hCC, 32'hCC, 4'd2, 5'd3);
        tick("stall_hold");
        stall_in = 1'b0;

        // r0 never forwarded
        id_set(1, 0, 0, 9, 32'h0, 32'h5, 32'h0, 4'd1, 5'd0, 0, 1, 0, 0);
        fwd_set(1, 0, 32'hFF, 0, 0, 0);
        push(1, 1, 0, 0, 9, 32'h0, 32'h5, 32'h5, 4'd1, 5'd0);
        tick("r0");

        // Immediate operand vs forwarded store data
        id_set(1, 1, 6, 10, 32'h7, 32'h3, 32'hFFFF_FFFC, 4'd0, 5'd0, 1, 0, 0, 1);
        fwd_set(1, 6, 32'h10, 0, 0, 0);
        push(1, 0, 0, 1, 10, 32'h7, 32'hFFFF_FFFC, 32'h10, 4'd0, 5'd0);
        tick("store");

        // stall_in beats flush; flush alone then bubbles
        id_set(1, 2, 3, 11, 32'h55, 32'h66, 32'h0, 4'd5, 5'd1, 0, 1, 0, 0);
        stall_in = 1'b1; flush = 1'b1;
        push(1, 0, 0, 1, 10, 32'h7, 32'hFFFF_FFFC, 32'h10, 4'd0, 5'd0);
        tick("stall_flush");
        stall_in = 1'b0;
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("flush");
        flush = 1'b0;

        // Flush masks hazard, stall_in does not; reset overrides stall
        fwd_set(0, 0, 0, 0, 0, 0);
        id_set(1, 1, 2, 5, 32'h30, 32'h40, 32'h4, 4'd0, 5'd0, 1, 1, 1, 0);
        push(1, 1, 1, 0, 5, 32'h30, 32'h4, 32'h40, 4'd0, 5'd0);
        tick("load2");
        id_set(1, 9, 5, 13, 32'h1, 32'h2, 32'h0, 4'd0, 5'd0, 0, 1, 0, 0);
        flush = 1'b1;
        chk_lus("flush_mask.lus", 1'b0);
        flush = 1'b0; stall_in = 1'b1;
        chk_lus("stall_nomask.lus", 1'b1);
        push(1, 1, 1, 0, 5, 32'h30, 32'h4, 32'h40, 4'd0, 5'd0);
        tick("stall_load");
        chk_lus("stall_load.lus", 1'b1);
        rst = 1'b1;
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("rst_in_stall");
        chk_lus("rst_in_stall.lus", 1'b0);
        rst = 1'b0; stall_in = 1'b0;
        id_set(1, 3, 4, 12, 32'h9, 32'hA, 32'h0, 4'd3, 5'd4, 0, 1, 0, 0);
        push(1, 1, 0, 0, 12, 32'h9, 32'hA, 32'hA, 4'd3, 5'd4);
        tick("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; RTL and bench are built only at 32.
REQ-002 SHALL have parameter REG_W, default 5, register-index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 id_valid  input  1  decode slot holds a real instruction.
REQ-006 id_rs, id_rt, id_rd  input  REG_W each  source/destination indices.
REQ-007 id_rs_val, id_rt_val, id_imm  input  DATA_W each  register-file operands, sign-extended immediate.
REQ-008 id_alu_ctrl  input  4  ALU opcode (0000 add … 0111 slt); id_shamt  input  5.
REQ-009 id_alu_src, id_reg_write, id_mem_read, id_mem_write  input  1 each  control bits; alu_src=1 selects immediate for in2.
REQ-010 stall_in  input  1  downstream hold (cache miss); flush  input  1  branch squash.
REQ-011 exm_reg_write  input  1, exm_rd  input  REG_W, exm_result  input  DATA_W  EX/MEM forwarding source.
REQ-012 mwb_reg_write  input  1, mwb_rd  input  REG_W, mwb_result  input  DATA_W  MEM/WB forwarding source.
REQ-013 alu_in1, alu_in2  output  DATA_W; alu_ctrl  output  4; alu_shamt  output  5  ALU operands.
REQ-014 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  output  1 each; ex_rd  output  REG_W; ex_store_data  output  DATA_W.
REQ-015 load_use_stall  output  1  request to hold PC and IF/ID.

Function
REQ-016 SHALL hold one pipeline register (valid, rs, rt, rd, rs_val, rt_val, imm, alu_ctrl, shamt, alu_src, reg_write, mem_read, mem_write).
REQ-017 Register update priority each edge SHALL be: rst > stall_in (hold all) > flush (bubble) > load_use_stall (bubble) > load from ID.
REQ-018 Bubble SHALL clear valid, reg_write, mem_read, mem_write; data fields don't-care but SHALL be zeroed.
REQ-019 load_use_stall SHALL be combinational: id_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt).
REQ-020 load_use_stall SHALL be forced 0 while flush=1; stall_in does not mask it.
REQ-021 Forwarding SHALL be combinational on registered rs/rt: EX/MEM match (exm_reg_write, exm_rd!=0, exm_rd==reg) wins over MEM/WB match; else registered value.
REQ-022 Register index 0 SHALL never be forwarded; operand is the registered value.
REQ-023 alu_in1 SHALL equal forwarded rs; alu_in2 SHALL equal imm when alu_src=1, else forwarded rt.
REQ-024 ex_store_data SHALL always equal forwarded rt, independent of alu_src.
REQ-025 ex_* control outputs SHALL be the registered fields gated by valid (0 when valid=0).
REQ-026 alu_ctrl and alu_shamt SHALL be registered fields, unmodified.
REQ-027 Latency: ID inputs appear on outputs one cycle after a non-stalled, non-flushed edge.
REQ-028 Stall_in held N cycles SHALL keep outputs' registered part constant N cycles; forwarded values may change with forwarding inputs.

Reset
REQ-029 On rst, valid and all control bits SHALL be 0 and all data fields 0 by next edge; alu_in1=alu_in2=0, alu_ctrl=0000, alu_shamt=0, load_use_stall=0.
REQ-030 rst asserted mid-stall or mid-flush SHALL override both; first post-reset edge with id_valid=1 loads normally.

Verification
REQ-031 Load r5 (mem_read, rd=5) in EX; ID add rs=5 -> load_use_stall=1 same cycle, next cycle ex_valid=0, ex_reg_write=0.
REQ-032 EX reg rs=3 rs_val=1; exm_rd=3 result=0xAA, mwb_rd=3 result=0xBB -> alu_in1=0xAA; exm_reg_write=0 -> 0xBB.
REQ-033 rs=0, exm_rd=0 exm_reg_write=1 result=0xFF -> alu_in1=registered value (0).
REQ-034 alu_src=1 imm=0xFFFFFFFC, rt fwd 0x10 -> alu_in2=0xFFFFFFFC, ex_store_data=0x10.
REQ-035 stall_in=1 and flush=1 same edge -> registered state unchanged; flush alone next edge -> ex_valid=0.
REQ-036 rst pulsed while stall_in=1 with valid load in EX -> all outputs 0, load_use_stall=0 next cycle.
